// File: rtl/button_press_ctrl.sv
// Button press classifier: turns a debounced button level into one-cycle
// short / long / double press pulses, and keeps a wrapping count of pulses issued.
module button_press_ctrl #(
  parameter int unsigned LONG_CNT = 100,
  parameter int unsigned GAP_CNT  = 50,
  parameter int unsigned CW       = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       but_i,
  output logic       short_o,
  output logic       long_o,
  output logic       double_o,
  output logic       busy_o,
  output logic [7:0] evt_cnt_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PRESS1 = 3'd1;
  localparam logic [2:0] S_HOLD   = 3'd2;
  localparam logic [2:0] S_GAP    = 3'd3;
  localparam logic [2:0] S_PRESS2 = 3'd4;

  // Last count value before the long-press / gap timeout fires.
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CNT - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CNT - 1);

  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_but_q;
  logic          r_short;
  logic          r_long;
  logic          r_double;
  logic          r_busy;
  logic [7:0]    r_evt;

  logic [2:0]    w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_short;
  logic          w_long;
  logic          w_double;
  logic          w_rise;

  assign w_rise = but_i & ~r_but_q;

  // Next-state, counter and pulse decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_short     = 1'b0;
    w_long      = 1'b0;
    w_double    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rise) begin
          w_state_nxt = S_PRESS1;
          w_cnt_nxt   = '0;
        end
      end
      S_PRESS1: begin
        // Release wins over the long-press timeout in the same cycle.
        if (!but_i) begin
          w_state_nxt = S_GAP;
          w_cnt_nxt   = '0;
        end else if (r_cnt == LONG_LAST) begin
          w_state_nxt = S_HOLD;
          w_long      = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_HOLD: begin
        if (!but_i) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_GAP: begin
        // A second press wins over the gap timeout in the same cycle.
        if (but_i) begin
          w_state_nxt = S_PRESS2;
        end else if (r_cnt == GAP_LAST) begin
          w_state_nxt = S_IDLE;
          w_short     = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_PRESS2: begin
        if (!but_i) begin
          w_state_nxt = S_IDLE;
          w_double    = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State, edge-detect register, registered pulses and event counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_but_q  <= 1'b0;
      r_short  <= 1'b0;
      r_long   <= 1'b0;
      r_double <= 1'b0;
      r_busy   <= 1'b0;
      r_evt    <= 8'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_but_q  <= but_i;
      r_short  <= w_short;
      r_long   <= w_long;
      r_double <= w_double;
      r_busy   <= (w_state_nxt != S_IDLE);
      if (w_short || w_long || w_double) begin
        r_evt <= r_evt + 8'd1;
      end
    end
  end

  assign short_o   = r_short;
  assign long_o    = r_long;
  assign double_o  = r_double;
  assign busy_o    = r_busy;
  assign evt_cnt_o = r_evt;

endmodule

// File: tb/tb_button_press_ctrl.sv
// Bench for button_press_ctrl: timestamp-based press model checked every cycle,
// plus literal expectations at the interesting points of each scenario.
module tb_button_press_ctrl;

  localparam int LONG = 8;
  localparam int GAP  = 6;

  logic       clk;
  logic       rstn;
  logic       but_i;
  logic       short_o;
  logic       long_o;
  logic       double_o;
  logic       busy_o;
  logic [7:0] evt_cnt_o;

  int n_tests;
  int n_fail;

  button_press_ctrl #(
    .LONG_CNT(LONG),
    .GAP_CNT (GAP),
    .CW      (16)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .but_i    (but_i),
    .short_o  (short_o),
    .long_o   (long_o),
    .double_o (double_o),
    .busy_o   (busy_o),
    .evt_cnt_o(evt_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a press sequence is described by the edge index of its first rise
  // and of its first release; outputs follow from elapsed edge counts.
  int m_n;
  bit m_act;
  bit m_sec;
  bit m_longd;
  int m_ps;
  int m_pf;
  bit m_bq;
  bit m_b;
  bit e_short;
  bit e_long;
  bit e_double;
  int e_evt;

  initial begin
    m_n = 0; m_act = 0; m_sec = 0; m_longd = 0; m_ps = 0; m_pf = -1; m_bq = 0;
    e_short = 0; e_long = 0; e_double = 0; e_evt = 0;
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
        m_act = 0; m_sec = 0; m_longd = 0; m_pf = -1; m_bq = 0;
        e_short = 0; e_long = 0; e_double = 0; e_evt = 0;
      end else begin
        m_n++;
        m_b = but_i;
        e_short = 0; e_long = 0; e_double = 0;
        if (!m_act) begin
          if (m_b && !m_bq) begin
            m_act = 1; m_ps = m_n; m_pf = -1; m_sec = 0; m_longd = 0;
          end
        end else if (m_longd) begin
          if (!m_b) m_act = 0;
        end else if (m_sec) begin
          if (!m_b) begin m_act = 0; e_double = 1; end
        end else if (m_pf < 0) begin
          if (!m_b) m_pf = m_n;
          else if (m_n - m_ps == LONG) begin m_longd = 1; e_long = 1; end
        end else begin
          if (m_b) m_sec = 1;
          else if (m_n - m_pf == GAP) begin m_act = 0; e_short = 1; end
        end
        if (e_short || e_long || e_double) e_evt = (e_evt + 1) % 256;
        m_bq = m_b;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("model_short", 32'(short_o), 32'(e_short));
      chk("model_long", 32'(long_o), 32'(e_long));
      chk("model_double", 32'(double_o), 32'(e_double));
      chk("model_busy", 32'(busy_o), 32'(m_act));
      chk("model_evt", 32'(evt_cnt_o), 32'(e_evt));
      chk("one_hot_pulse", 32'(int'(short_o) + int'(long_o) + int'(double_o) <= 1), 32'd1);
    end
  end

  // Drive level b so that it is sampled by the next n edges; ends 1 ns after an edge.
  task automatic hold(input logic b, input int n);
    but_i = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rstn  = 1'b0;
    but_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    hold(1'b0, 3);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rstn    = 1'b0;
    but_i   = 1'b0;

    // Long reset with a toggling button: everything stays quiet.
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (i % 10 == 0) but_i = ~but_i;
    end
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_evt", 32'(evt_cnt_o), 32'd0);
    chk("rst_pulses", 32'({short_o, long_o, double_o}), 32'd0);
    but_i = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    hold(1'b0, 3);

    // Short press: 3 high, then short_o 6 edges after the fall edge.
    do_reset();
    hold(1'b1, 3);
    hold(1'b0, 6);
    chk("short_early", 32'(short_o), 32'd0);
    hold(1'b0, 1);
    chk("short_pulse", 32'(short_o), 32'd1);
    chk("short_evt", 32'(evt_cnt_o), 32'd1);
    hold(1'b0, 1);
    chk("short_one_cycle", 32'(short_o), 32'd0);
    chk("short_idle", 32'(busy_o), 32'd0);

    // Long press: long_o 8 edges after the rise edge, silent release.
    do_reset();
    hold(1'b1, 8);
    chk("long_early", 32'(long_o), 32'd0);
    chk("long_busy", 32'(busy_o), 32'd1);
    hold(1'b1, 1);
    chk("long_pulse", 32'(long_o), 32'd1);
    hold(1'b1, 11);
    hold(1'b0, 1);
    chk("long_release_idle", 32'(busy_o), 32'd0);
    hold(1'b0, 10);
    chk("long_evt", 32'(evt_cnt_o), 32'd1);

    // Double press.
    do_reset();
    hold(1'b1, 3);
    hold(1'b0, 2);
    hold(1'b1, 3);
    hold(1'b0, 1);
    chk("double_pulse", 32'(double_o), 32'd1);
    hold(1'b0, 10);
    chk("double_evt", 32'(evt_cnt_o), 32'd1);

    // Release exactly at the long-press boundary: short, not long.
    do_reset();
    hold(1'b1, 8);
    hold(1'b0, 6);
    chk("bnd_a_early", 32'(short_o), 32'd0);
    hold(1'b0, 1);
    chk("bnd_a_short", 32'(short_o), 32'd1);
    hold(1'b0, 3);
    chk("bnd_a_evt", 32'(evt_cnt_o), 32'd1);

    // Second press exactly at the gap boundary: double, not short.
    do_reset();
    hold(1'b1, 3);
    hold(1'b0, 6);
    hold(1'b1, 2);
    hold(1'b0, 1);
    chk("bnd_b_double", 32'(double_o), 32'd1);
    hold(1'b0, 10);
    chk("bnd_b_evt", 32'(evt_cnt_o), 32'd1);

    // Reset during the second press aborts with no pulse.
    do_reset();
    hold(1'b1, 3);
    hold(1'b0, 2);
    hold(1'b1, 2);
    chk("abort_busy_before", 32'(busy_o), 32'd1);
    rstn = 1'b0;
    #1;
    chk("abort_busy", 32'(busy_o), 32'd0);
    @(posedge clk); #1;
    but_i = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    hold(1'b0, 5);
    chk("abort_evt", 32'(evt_cnt_o), 32'd0);
    chk("abort_double", 32'(double_o), 32'd0);

    // Button already held when reset is released: first edge starts a press.
    @(posedge clk); #1;
    rstn  = 1'b0;
    but_i = 1'b1;
    @(posedge clk); #1;
    rstn = 1'b1;
    hold(1'b1, 1);
    chk("held_at_release_busy", 32'(busy_o), 32'd1);
    hold(1'b0, 12);
    chk("held_at_release_evt", 32'(evt_cnt_o), 32'd1);

    // Event counter wraps after 256 short presses.
    do_reset();
    for (int i = 0; i < 255; i++) begin
      hold(1'b1, 2);
      hold(1'b0, 8);
    end
    chk("wrap_255", 32'(evt_cnt_o), 32'd255);
    hold(1'b1, 2);
    hold(1'b0, 8);
    chk("wrap_0", 32'(evt_cnt_o), 32'd0);

    hold(1'b0, 2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
